// File: rtl/tl_sensor_cond.sv
// ============================================================================
//  Module   : tl_sensor_cond
//  Purpose  : Two-channel road-sensor conditioner (sync, debounce, hold-extend)
//             feeding the traffic light controller. Optional sticky requests
//             are enabled with `define TL_SENSOR_STICKY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ta_raw,
    input  logic tb_raw,
    input  logic clr_a,
    input  logic clr_b,
    output logic ta,
    output logic tb,
    output logic ta_rise,
    output logic tb_rise,
    output logic ta_req,
    output logic tb_req
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RISE = 2'b01,
        ST_ON   = 2'b10,
        ST_FALL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;

    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_rise;
    logic [1:0] w_clr;
    logic [1:0] w_req;

    assign w_raw = {tb_raw, ta_raw};
    assign w_clr = {clr_b, clr_a};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            logic           r_s1;
            logic           r_s2;
            state_t         r_state;
            state_t         w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic           r_level;
            logic           r_rise;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_state <= ST_OFF;
                    r_cnt   <= c_cnt_zero;
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                end else begin
                    r_s1    <= w_raw[g];
                    r_s2    <= r_s1;
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    // Outputs are flopped from the next state so they align with it.
                    r_level <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_FALL);
                    r_rise  <= (r_state == ST_RISE) && (w_state_nxt == ST_ON);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    ST_OFF: begin
                        if (r_s2) begin
                            w_state_nxt = ST_RISE;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                    ST_RISE: begin
                        if (!r_s2) begin
                            w_state_nxt = ST_OFF;
                            w_cnt_nxt   = c_cnt_zero;
                        end else if (r_cnt == c_deb_last) begin
                            w_state_nxt = ST_ON;
                            w_cnt_nxt   = c_cnt_zero;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_cnt_one;
                        end
                    end
                    ST_ON: begin
                        if (!r_s2) begin
                            w_state_nxt = ST_FALL;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                    ST_FALL: begin
                        if (r_s2) begin
                            w_state_nxt = ST_ON;
                            w_cnt_nxt   = c_cnt_zero;
                        end else if (r_cnt == c_hold_last) begin
                            w_state_nxt = ST_OFF;
                            w_cnt_nxt   = c_cnt_zero;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = c_cnt_zero;
                    end
                endcase
            end

            assign w_level[g] = r_level;
            assign w_rise[g]  = r_rise;
        end
    endgenerate

`ifdef TL_SENSOR_STICKY_EN
    generate
        for (genvar g = 0; g < 2; g++) begin : g_req
            logic r_req;

            // A new arrival outranks a clear arriving in the same cycle.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_req <= 1'b0;
                end else if (w_rise[g]) begin
                    r_req <= 1'b1;
                end else if (w_clr[g]) begin
                    r_req <= 1'b0;
                end
            end

            assign w_req[g] = r_req;
        end
    endgenerate
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_clr};
    assign w_req    = 2'b00;
`endif

    assign ta      = w_level[0];
    assign tb      = w_level[1];
    assign ta_rise = w_rise[0];
    assign tb_rise = w_rise[1];
    assign ta_req  = w_req[0];
    assign tb_req  = w_req[1];

endmodule

`default_nettype wire
